mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates a single shared memory bus between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage ARM pipeline.
- Sequences each access with a request/acknowledge handshake on the bus side and a one-cycle ready pulse on the requester side.
- Generates the freeze signals that stall IF and the rest of the pipeline while accesses are outstanding.
- Sits between the pipeline top and the external SRAM/bus model.

Parameters:
- ADDR_W, 32, address width for both requesters and the bus.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, number of consecutive data grants allowed while if_req is pending before fetch is forced to win; 1..15.
- TIMEOUT, 255, bus cycles to wait for bus_ack before aborting; 0 disables timeout; 0..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- mem_rd_en  in  1  data read request, level.
- mem_wr_en  in  1  data write request, level.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; valid while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for data.
- freeze_if  out  1  stall IF/IF-reg.
- freeze_pipe  out  1  stall ID/EXE/MEM/WB regs.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  write strobe, registered.
- bus_addr  out  ADDR_W  registered.
- bus_wdata  out  DATA_W  registered.
- bus_rdata  in  DATA_W  valid in the bus_ack cycle.
- bus_ack  in  1  one-cycle acknowledge.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- **Reset:** while rst=0, all of the following are forced immediately (asynchronous): state=IDLE, all outputs 0, rdata registers 0, starvation counter 0, timeout counter 0. An access in flight is dropped; bus_req falls without waiting for the clock.
- **States:**
  - IDLE: samples requests at the clock edge.
  - GNT_D: data access on the bus.
  - GNT_I: fetch access on the bus.
  - RESP_D / RESP_I: ready pulse cycle.
- **IDLE arbitration:**
  - If (mem_rd_en|mem_wr_en), data wins, unless if_req=1 and starve_cnt==STARVE_LIMIT, in which case fetch wins.
  - Otherwise, if if_req=1, fetch wins.
  - Otherwise, stay in IDLE.
- **Starvation counter:** starve_cnt increments on each data grant while if_req=1, saturating at STARVE_LIMIT. It clears on every fetch grant.
- **Entering a grant state:** bus_req=1, and bus_addr/bus_we/bus_wdata are latched. These stay stable until ack or timeout.
- **Read/write conflict:** if mem_rd_en and mem_wr_en are both 1, the write wins and the read is ignored.
- **Grant state with bus_ack=1:** capture bus_rdata into the corresponding rdata register, drop bus_req, then go to RESP_x.
- **RESP_x:**
  - x_ready=1 for exactly one cycle, then go to IDLE.
  - mem_rdata is not updated on writes.
  - RESP never arbitrates directly. The next grant requires passing through IDLE, so a requester always has one cycle to drop or change its request.
- **Latency:** with ack in the first bus cycle, request sampled at edge N → bus_req high in cycle N+1 → ready in cycle N+2 → IDLE in cycle N+3. Throughput is at most 1 access per 3 cycles.
- **Timeout** (TIMEOUT>0):
  - The counter counts grant-state cycles without ack.
  - On reaching TIMEOUT: drop bus_req, set bus_err=1 (sticky until reset), load rdata=32'hDEADBEEF, and go to RESP_x. A write completes as if acknowledged.
- **Spurious ack:** bus_ack in IDLE or RESP is ignored.
- **Freeze outputs** (combinational from registered state and inputs):
  - freeze_pipe = (mem_rd_en|mem_wr_en) & ~mem_ready.
  - freeze_if = freeze_pipe | (if_req & ~if_ready).
  - Neither freeze is asserted while rst=0.

Decomposition:
- **Package arm_mem_pkg:**
  - state enum: IDLE, GNT_D, GNT_I, RESP_D, RESP_I.
  - constant BUS_ERR_DATA = 32'hDEADBEEF.
  - widths for the starvation and timeout counters.
- **Sub-module mem_arb_timer:** load/count/expire counter parameterised by TIMEOUT. It is cleared on ack and on grant entry.

Test Plan:
- if_req=1, addr=0x10; bus_ack on the first bus cycle with rdata=0xE3A00001 → if_ready pulses in cycle 2 with if_rdata=0xE3A00001; bus_req high only in cycle 1.
- if_req and mem_rd_en (addr=0x100) both asserted → data granted first, freeze_pipe=1 until mem_ready; fetch is granted on the next IDLE.
- STARVE_LIMIT=4, data requests continuous, if_req held → four data grants, then the fifth grant goes to fetch; starve_cnt returns to 0.
- mem_wr_en=1, addr=0x200, wdata=0x12345678, ack delayed 3 cycles → bus_we=1 and bus_addr/bus_wdata stable for all 4 bus cycles; mem_ready pulses once; mem_rdata unchanged.
- TIMEOUT=8, no ack → bus_req drops after 8 cycles; mem_ready pulses with mem_rdata=0xDEADBEEF; bus_err=1 and stays 1.
- rst pulled low mid-GNT_I → bus_req and freezes drop 0 without waiting for an edge; after release, state=IDLE and a new request is served normally.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package arm_mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GNT_D,
      GNT_I,
      RESP_D,
      RESP_I
   } arb_state_e;

   localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

   // STARVE_LIMIT fits 1..15, TIMEOUT fits 0..255
   localparam int unsigned STARVE_W = 4;
   localparam int unsigned TMR_W    = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// Bus-ack watchdog: counts grant cycles without ack, flags expiry; TIMEOUT=0 never expires.
module mem_arb_timer
   import arm_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds the cycles already spent, so expiry fires in the TIMEOUT-th grant cycle
   assign expire_c = (TIMEOUT != 0) && en && (cnt_q == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and data access; drives pipeline freezes.
module mem_arbiter
   import arm_mem_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              mem_rd_en,
   input  logic              mem_wr_en,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              freeze_if,
   output logic              freeze_pipe,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              bus_err
);

   arb_state_e          state_q, state_d;
   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   logic                bus_req_q, bus_req_d;
   logic                bus_we_q, bus_we_d;
   logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
   logic                if_ready_q, if_ready_d;
   logic                mem_ready_q, mem_ready_d;
   logic                bus_err_q, bus_err_d;

   logic                data_req_c;
   logic                in_grant_c;
   logic                starved_c;
   logic                tmr_expire_c;
   logic [DATA_W-1:0]   resp_data_c;

   assign data_req_c  = mem_rd_en | mem_wr_en;
   assign in_grant_c  = (state_q == GNT_D) || (state_q == GNT_I);
   assign starved_c   = if_req && (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
   assign resp_data_c = bus_ack ? bus_rdata : DATA_W'(BUS_ERR_DATA);

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (~in_grant_c | bus_ack),
      .en       (in_grant_c & ~bus_ack),
      .expire_c (tmr_expire_c)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      bus_req_d    = bus_req_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      if_rdata_d   = if_rdata_q;
      mem_rdata_d  = mem_rdata_q;
      if_ready_d   = 1'b0;
      mem_ready_d  = 1'b0;
      bus_err_d    = bus_err_q;

      case (state_q)
         IDLE: begin
            if (data_req_c && !starved_c) begin
               state_d     = GNT_D;
               bus_req_d   = 1'b1;
               bus_we_d    = mem_wr_en;
               bus_addr_d  = mem_addr;
               bus_wdata_d = mem_wdata;
               // Cannot overflow: at the limit a pending fetch takes this slot instead
               if (if_req) begin
                  starve_cnt_d = starve_cnt_q + STARVE_W'(1);
               end
            end else if (if_req) begin
               state_d      = GNT_I;
               bus_req_d    = 1'b1;
               bus_we_d     = 1'b0;
               bus_addr_d   = if_addr;
               starve_cnt_d = '0;
            end
         end

         GNT_D, GNT_I: begin
            if (bus_ack || tmr_expire_c) begin
               bus_req_d = 1'b0;
               bus_we_d  = 1'b0;
               bus_err_d = bus_err_q | ~bus_ack;
               if (state_q == GNT_D) begin
                  state_d     = RESP_D;
                  mem_ready_d = 1'b1;
                  if (!bus_we_q) begin
                     mem_rdata_d = resp_data_c;
                  end
               end else begin
                  state_d    = RESP_I;
                  if_ready_d = 1'b1;
                  if_rdata_d = resp_data_c;
               end
            end
         end

         RESP_D, RESP_I: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
         if_ready_q   <= 1'b0;
         mem_ready_q  <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         bus_req_q    <= bus_req_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         if_rdata_q   <= if_rdata_d;
         mem_rdata_q  <= mem_rdata_d;
         if_ready_q   <= if_ready_d;
         mem_ready_q  <= mem_ready_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign if_ready  = if_ready_q;
   assign mem_ready = mem_ready_q;
   assign bus_err   = bus_err_q;

   // Freezes follow the request inputs directly and are held off during reset
   assign freeze_pipe = rst & data_req_c & ~mem_ready_q;
   assign freeze_if   = rst & (data_req_c & ~mem_ready_q | if_req & ~if_ready_q);

endmodule
